// File: rtl/parametros_tempo_pkg.sv
// Shared definitions for the alarm timing parameters: slot encoding and factory defaults.
// Used by the parameter store, the timer and the user-interface blocks.
package parametros_tempo_pkg;

    localparam int unsigned SLOT_W  = 2;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned VALUE_W = 5;
    localparam int unsigned N_SLOTS = 4;

    typedef enum logic [SLOT_W-1:0] {
        SLOT_ARM       = 2'd0,
        SLOT_DRIVER    = 2'd1,
        SLOT_PASSENGER = 2'd2,
        SLOT_ALARM     = 2'd3
    } slot_e;

    localparam logic [LEN_W-1:0] DEF_ARM_VAL       = 4'd6;
    localparam logic [LEN_W-1:0] DEF_DRIVER_VAL    = 4'd8;
    localparam logic [LEN_W-1:0] DEF_PASSENGER_VAL = 4'd15;
    localparam logic [LEN_W-1:0] DEF_ALARM_VAL     = 4'd10;

endpackage

// File: rtl/parametros_tempo.sv
// Programmable store of four alarm interval lengths with factory defaults and a
// combinational read port toward the timer.
module parametros_tempo
    import parametros_tempo_pkg::*;
#(
    parameter logic [3:0] DEF_ARM       = DEF_ARM_VAL,
    parameter logic [3:0] DEF_DRIVER    = DEF_DRIVER_VAL,
    parameter logic [3:0] DEF_PASSENGER = DEF_PASSENGER_VAL,
    parameter logic [3:0] DEF_ALARM     = DEF_ALARM_VAL
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    input  logic       reprogram,
    input  logic [1:0] interval,
    output logic [4:0] value
);

    logic [LEN_W-1:0] slot_r [N_SLOTS];
    logic [LEN_W-1:0] wr_data_s;
    logic [LEN_W-1:0] rd_data_s;

    function automatic logic [LEN_W-1:0] default_of(input logic [SLOT_W-1:0] sel);
        logic [LEN_W-1:0] def;
        case (sel)
            SLOT_ARM:       def = DEF_ARM;
            SLOT_DRIVER:    def = DEF_DRIVER;
            SLOT_PASSENGER: def = DEF_PASSENGER;
            SLOT_ALARM:     def = DEF_ALARM;
            default:        def = DEF_ARM;
        endcase
        return def;
    endfunction

    // A zero length would make an interval expire instantly, so it falls back to the default.
    always_comb begin
        wr_data_s = time_value;
        if (time_value == 4'd0) begin
            wr_data_s = default_of(time_param_sel);
        end else begin
            wr_data_s = time_value;
        end
    end

    // Register bank: reset wins over any write in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            slot_r[SLOT_ARM]       <= DEF_ARM;
            slot_r[SLOT_DRIVER]    <= DEF_DRIVER;
            slot_r[SLOT_PASSENGER] <= DEF_PASSENGER;
            slot_r[SLOT_ALARM]     <= DEF_ALARM;
        end else if (reprogram) begin
            slot_r[time_param_sel] <= wr_data_s;
        end else begin
            slot_r <= slot_r;
        end
    end

    // Zero-latency read mux; the timer needs the value in the same cycle it selects it.
    always_comb begin
        rd_data_s = slot_r[SLOT_ARM];
        case (interval)
            SLOT_ARM:       rd_data_s = slot_r[SLOT_ARM];
            SLOT_DRIVER:    rd_data_s = slot_r[SLOT_DRIVER];
            SLOT_PASSENGER: rd_data_s = slot_r[SLOT_PASSENGER];
            SLOT_ALARM:     rd_data_s = slot_r[SLOT_ALARM];
            default:        rd_data_s = slot_r[SLOT_ARM];
        endcase
    end

    assign value = {1'b0, rd_data_s};

endmodule

// File: tb/tb_parametros_tempo.sv
// Directed self-checking bench for parametros_tempo: defaults, writes, zero-write fallback,
// reset priority and same-slot write/read timing.
module tb_parametros_tempo;

    logic       clock;
    logic       reset;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       reprogram;
    logic [1:0] interval;
    logic [4:0] value;

    int n_assert = 0;
    int n_fail   = 0;

    parametros_tempo dut (
        .clock          (clock),
        .reset          (reset),
        .time_param_sel (time_param_sel),
        .time_value     (time_value),
        .reprogram      (reprogram),
        .interval       (interval),
        .value          (value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [4:0] expected);
        n_assert++;
        assert (value === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, value, expected);
        end
    endtask

    // Advance one full cycle; inputs change and outputs are sampled near the falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic look(input logic [1:0] iv, input string tag, input logic [4:0] expected);
        interval = iv;
        #1;
        check(tag, expected);
    endtask

    task automatic write(input logic [1:0] sel, input logic [3:0] tv);
        time_param_sel = sel;
        time_value     = tv;
        reprogram      = 1'b1;
        tick();
        reprogram      = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        time_param_sel = 2'd0;
        time_value     = 4'd0;
        reprogram      = 1'b0;
        interval       = 2'd0;
        @(negedge clock);

        // Reset defaults
        reset = 1'b0;
        tick();
        reset = 1'b1;
        look(2'd0, "rst_arm",       5'd6);
        look(2'd1, "rst_driver",    5'd8);
        look(2'd2, "rst_passenger", 5'd15);
        look(2'd3, "rst_alarm",     5'd10);

        // Reprogram one slot, others unchanged
        write(2'd1, 4'd5);
        look(2'd1, "wr_driver",       5'd5);
        look(2'd0, "keep_arm",        5'd6);
        look(2'd2, "keep_passenger",  5'd15);
        look(2'd3, "keep_alarm",      5'd10);

        // Zero write restores default
        write(2'd2, 4'd7);
        look(2'd2, "wr_passenger_7",  5'd7);
        write(2'd2, 4'd0);
        look(2'd2, "zero_passenger",  5'd15);
        write(2'd0, 4'd3);
        look(2'd0, "wr_arm_3",        5'd3);
        write(2'd0, 4'd0);
        look(2'd0, "zero_arm",        5'd6);
        write(2'd3, 4'd15);
        look(2'd3, "wr_alarm_max",    5'd15);

        // Reset after programming
        look(2'd1, "pre_reset_driver", 5'd5);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        look(2'd1, "post_reset_driver", 5'd8);
        look(2'd3, "post_reset_alarm",  5'd10);

        // Reset priority over a simultaneous write
        reset          = 1'b0;
        time_param_sel = 2'd3;
        time_value     = 4'd2;
        reprogram      = 1'b1;
        tick();
        reset     = 1'b1;
        reprogram = 1'b0;
        look(2'd3, "rst_priority", 5'd10);

        // Same-slot write/read: old before edge, new after, held strobe idempotent
        interval       = 2'd3;
        time_param_sel = 2'd3;
        time_value     = 4'd12;
        reprogram      = 1'b1;
        #1;
        check("same_slot_before", 5'd10);
        tick();
        #1;
        check("same_slot_after", 5'd12);
        tick();
        #1;
        check("hold_cycle2", 5'd12);
        tick();
        reprogram = 1'b0;
        #1;
        check("hold_cycle3", 5'd12);
        look(2'd0, "hold_other_arm", 5'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/parametros_tempo.md
# parametros_tempo

Programmable timing-parameter store for the alarm controller. It holds four 4-bit interval lengths in seconds: arm delay, driver-door delay, passenger-door delay and siren-on time. Each interval starts at a factory default and can be overwritten one at a time from the user interface. The timer block selects an interval and receives its length on a 5-bit bus.

## Interface
Parameters:
- DEF_ARM, 4'd6, factory value of slot 0 (arm delay)
- DEF_DRIVER, 4'd8, factory value of slot 1 (driver-door delay)
- DEF_PASSENGER, 4'd15, factory value of slot 2 (passenger-door delay)
- DEF_ALARM, 4'd10, factory value of slot 3 (siren-on time)

Ports:
- clock  in  1  single system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-low reset (sampled on rising clock edge only)
- time_param_sel  in  2  slot to reprogram (0 arm, 1 driver, 2 passenger, 3 alarm)
- time_value  in  4  new length in seconds for the selected slot
- reprogram  in  1  write strobe, level-sensitive, sampled each rising edge
- interval  in  2  slot to read, same encoding as time_param_sel
- value  out  5  length of the slot selected by interval, zero-extended (bit 4 always 0)

## Operation
- Storage: four 4-bit registers, slot[0..3].
- Reset (reset==0 at an edge): all four slots load their DEF_* values, and any reprogram in the same cycle is ignored.
- Write (reset==1, reprogram==1 at an edge): slot[time_param_sel] <= time_value. If time_value==0, the slot loads its own DEF_* value instead, so a zero-length interval can never be stored. Other slots are unchanged.
- reprogram held high for N cycles rewrites the same slot N times; the result is idempotent.
- Read: value = {1'b0, slot[interval]}. This is a combinational mux from the registers, with no register on the output path.
- Unknown or X inputs are not sanitized. Undriven reprogram is treated as 0 by the integration.
- No other state exists: no FSM, no counters.

## Timing
- Write latency: value reflects a write to the currently selected slot immediately after the writing edge, meaning the same cycle the register updates. Before the edge it shows the old contents.
- Read latency: zero cycles. A change on interval propagates combinationally to value.
- Reset output: after the reset edge, value equals the selected default: 6, 8, 15 or 10 for interval 0 to 3.
- Simultaneous write and read of the same slot: value shows the old value until the edge and the new value after it.
- Reset asserted mid-operation discards all programmed values at the next edge.
- Before the first reset edge, register contents are undefined. No power-on initialization is required.

## Structure
- Shared package: slot index encoding constants (ARM=0, DRIVER=1, PASSENGER=2, ALARM=3) and the four default values. The timer and UI blocks use the same package.
- Single flat module: the register bank with write-decode logic and a 4:1 read mux. No sub-module is needed.
- The optional register-bank sub-module param_regfile (4x4 registers, one write port, one async read port) may be factored out if it is reused.

## Test plan
- Reset defaults: reset low for 1 cycle, then sweep interval 0..3 -> value = 6, 8, 15, 10.
- Reprogram one slot: sel=1, time_value=5, reprogram=1 for 1 cycle, then interval=1 -> value=5; interval=0,2,3 -> 6, 15, 10, since other slots are unchanged.
- Zero write restores default: sel=2, time_value=7 written, then sel=2, time_value=0 written -> interval=2 gives 15.
- Reset after programming: program slot 1 to 5, then reset low 1 cycle with interval=1 -> value returns to 8 on the edge.
- Reset priority: reset low and reprogram high (sel=3, value=2) in the same cycle -> slot 3 reads 10, not 2.
- Write/read same slot: interval=3 and program sel=3 to 12 -> value is 10 before the edge and 12 after it. Holding reprogram high for 3 cycles keeps value at 12.
